// File: rtl/uart_rx.sv
// UART receiver: recovers start/data/stop frames from an idle-high serial line
// and writes each good word into a FIFO; framing errors and overruns pulse once.
module uart_rx #(
  parameter int p_delay_cnt = 868,
  parameter int p_bit_cnt   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sig,
  output logic [p_bit_cnt-1:0] o_fifo_wr_data,
  output logic                 o_fifo_wr_en,
  input  logic                 i_fifo_full,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int DW = $clog2(p_delay_cnt) + 1;
  localparam int BW = $clog2(p_bit_cnt) + 1;
  localparam logic [DW-1:0] DLY_FULL = DW'(p_delay_cnt);
  localparam logic [DW-1:0] DLY_HALF = DW'(p_delay_cnt / 2);
  localparam logic [BW-1:0] BITS     = BW'(p_bit_cnt);

  typedef enum logic [2:0] {
    s_idle,
    s_start,
    s_data,
    s_stop,
    s_wait
  } state_t;

  state_t               state;
  logic [1:0]           r_sync;
  logic [DW-1:0]        r_delay_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [p_bit_cnt-1:0] r_shift;
  logic                 s;
  logic                 tick;

  assign s    = r_sync[1];
  assign tick = (r_delay_cnt == DW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync         <= 2'b11;
      state          <= s_idle;
      r_delay_cnt    <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      o_fifo_wr_data <= '0;
      o_fifo_wr_en   <= 1'b0;
      o_frame_err    <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_sig};
      o_fifo_wr_en <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      case (state)
        s_idle: begin
          if (!s) begin
            state       <= s_start;
            r_delay_cnt <= DLY_HALF;
          end
        end
        // Mid start bit: a high line here means the falling edge was a glitch.
        s_start: begin
          if (tick) begin
            if (s) begin
              state <= s_idle;
            end else begin
              state       <= s_data;
              r_delay_cnt <= DLY_FULL;
              r_bit_cnt   <= BITS;
            end
          end else begin
            r_delay_cnt <= r_delay_cnt - DW'(1);
          end
        end
        s_data: begin
          if (tick) begin
            r_shift     <= {s, r_shift[p_bit_cnt-1:1]};
            r_delay_cnt <= DLY_FULL;
            if (r_bit_cnt == BW'(1)) state <= s_stop;
            else                     r_bit_cnt <= r_bit_cnt - BW'(1);
          end else begin
            r_delay_cnt <= r_delay_cnt - DW'(1);
          end
        end
        // Return to idle right after the stop sample so a short stop bit still works.
        s_stop: begin
          if (tick) begin
            if (s) begin
              state <= s_idle;
              if (i_fifo_full) begin
                o_overrun <= 1'b1;
              end else begin
                o_fifo_wr_en   <= 1'b1;
                o_fifo_wr_data <= r_shift;
              end
            end else begin
              state       <= s_wait;
              o_frame_err <= 1'b1;
            end
          end else begin
            r_delay_cnt <= r_delay_cnt - DW'(1);
          end
        end
        // A held-low (break) line must not look like a stream of start bits.
        s_wait: begin
          if (s) state <= s_idle;
        end
        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a behavioural serial driver feeds the line and a
// negedge monitor collects write strobes, framing errors and overruns.
module tb_uart_rx;

  localparam int PER = 16;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_sig = 1'b1;
  logic [7:0] o_fifo_wr_data;
  logic       o_fifo_wr_en;
  logic       i_fifo_full = 1'b0;
  logic       o_frame_err;
  logic       o_overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  int n_fe   = 0;
  int n_ov   = 0;
  logic [7:0] rxq[$];

  uart_rx #(.p_delay_cnt(PER), .p_bit_cnt(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_sig          (i_sig),
    .o_fifo_wr_data (o_fifo_wr_data),
    .o_fifo_wr_en   (o_fifo_wr_en),
    .i_fifo_full    (i_fifo_full),
    .o_frame_err    (o_frame_err),
    .o_overrun      (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_fifo_wr_en) begin
        n_wr++;
        rxq.push_back(o_fifo_wr_data);
      end
      if (o_frame_err) n_fe++;
      if (o_overrun)   n_ov++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    n_wr = 0; n_fe = 0; n_ov = 0;
    rxq.delete();
  endtask

  // stop_low extra bit times of low line model a broken stop bit
  task automatic send(input logic [7:0] d, input int per, input int stop_low);
    i_sig = 1'b0;
    tick(per);
    for (int j = 0; j < 8; j++) begin
      i_sig = d[j];
      tick(per);
    end
    if (stop_low > 0) begin
      i_sig = 1'b0;
      tick(stop_low * per);
    end
    i_sig = 1'b1;
    tick(per);
  endtask

  task automatic chk_q(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    if (rxq.size() == 0) begin
      chk(tag, 32'hdead, {24'd0, exp});
    end else begin
      v = rxq.pop_front();
      chk(tag, {24'd0, v}, {24'd0, exp});
    end
  endtask

  initial begin
    #2;
    chk("rst_wr_en", o_fifo_wr_en, 0);
    chk("rst_wr_data", o_fifo_wr_data, 0);
    chk("rst_frame_err", o_frame_err, 0);
    chk("rst_overrun", o_overrun, 0);
    tick(3);
    i_rst = 1'b0;
    tick(10);

    // back-to-back loopback bytes
    clr();
    send(8'hA5, PER, 0);
    send(8'h00, PER, 0);
    send(8'hFF, PER, 0);
    send(8'h3C, PER, 0);
    tick(8);
    chk("loop_count", n_wr, 4);
    chk_q("loop_b0", 8'hA5);
    chk_q("loop_b1", 8'h00);
    chk_q("loop_b2", 8'hFF);
    chk_q("loop_b3", 8'h3C);
    chk("loop_fe", n_fe, 0);
    chk("loop_ov", n_ov, 0);
    chk("hold_data", o_fifo_wr_data, 8'h3C);

    // short low glitch on an idle line
    clr();
    i_sig = 1'b0;
    tick(4);
    i_sig = 1'b1;
    tick(3 * PER);
    chk("glitch_wr", n_wr, 0);
    chk("glitch_fe", n_fe, 0);
    chk("glitch_ov", n_ov, 0);
    send(8'h5A, PER, 0);
    tick(4);
    chk("glitch_after_count", n_wr, 1);
    chk_q("glitch_after", 8'h5A);

    // stop bit held low for three bit times, then a good frame
    clr();
    send(8'h55, PER, 3);
    tick(PER);
    chk("ferr_pulse", n_fe, 1);
    chk("ferr_wr", n_wr, 0);
    send(8'h12, PER, 0);
    tick(4);
    chk("ferr_then_count", n_wr, 1);
    chk_q("ferr_then_data", 8'h12);
    chk("ferr_then_fe", n_fe, 1);

    // FIFO full during the stop sample drops the word
    clr();
    i_fifo_full = 1'b1;
    send(8'h81, PER, 0);
    tick(4);
    chk("ovr_pulse", n_ov, 1);
    chk("ovr_wr", n_wr, 0);
    i_fifo_full = 1'b0;
    send(8'h7E, PER, 0);
    tick(4);
    chk("ovr_then_count", n_wr, 1);
    chk_q("ovr_then_data", 8'h7E);
    chk("ovr_then_ov", n_ov, 1);

    // asynchronous reset in the middle of data bit 3
    clr();
    i_sig = 1'b0;
    tick(PER);
    for (int j = 0; j < 3; j++) begin
      i_sig = j[0];
      tick(PER);
    end
    i_sig = 1'b1;
    tick(PER / 2);
    #2;
    i_rst = 1'b1;
    #1;
    chk("midrst_wr_data", o_fifo_wr_data, 0);
    chk("midrst_wr_en", o_fifo_wr_en, 0);
    chk("midrst_fe", o_frame_err, 0);
    tick(3);
    i_rst = 1'b0;
    tick(12 * PER);
    chk("midrst_no_wr", n_wr, 0);
    chk("midrst_no_fe", n_fe, 0);
    send(8'hC3, PER, 0);
    tick(4);
    chk("midrst_count", n_wr, 1);
    chk_q("midrst_data", 8'hC3);

    // transmitter about 6% slow
    clr();
    send(8'h96, PER + 1, 0);
    tick(4);
    chk("skew_count", n_wr, 1);
    chk_q("skew_data", 8'h96);
    chk("skew_fe", n_fe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the downstream stage of uart_tx. It takes the serial line that uart_tx drives, recovers 8N1-style frames (start bit, p_bit_cnt data bits LSB first, one stop bit) and pushes each good data word into a write-side FIFO interface. It uses the same bit-timing parameter as uart_tx, so a tx/rx pair with equal p_delay_cnt interoperates in loopback. Framing errors and FIFO overruns are reported as single-cycle pulses.

Parameters:
p_delay_cnt, 868, clock cycles per UART bit; must be >= 4; identical meaning to the transmitter.
p_bit_cnt, 8, number of data bits per frame.

Ports:
i_clk  input  1  clock.
i_rst  input  1  reset, asynchronous, active-high.
i_sig  input  1  serial line, idle high; asynchronous to i_clk.
o_fifo_wr_data  output  p_bit_cnt  received word; valid when o_fifo_wr_en=1.
o_fifo_wr_en  output  1  one-cycle write strobe to the FIFO.
i_fifo_full  input  1  FIFO full; a write is suppressed while high.
o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
o_overrun  output  1  one-cycle pulse: good frame dropped because i_fifo_full=1.

Behaviour:
- Synchroniser: i_sig passes through 2 flops, both reset to 1. All decisions use the synchronised value s, giving 2 cycles of input latency.
- Reset (async, i_rst=1): state=s_idle; o_fifo_wr_en=0, o_frame_err=0, o_overrun=0, o_fifo_wr_data=0; shift register=0; counters=0. Reset mid-frame discards the partial frame with no pulse.
- Counters: r_delay_cnt is $clog2(p_delay_cnt)+1 bits wide and counts down, so each event fires when r_delay_cnt==1. r_bit_cnt is $clog2(p_bit_cnt)+1 bits wide.
- States:
  - s_idle: when s==0, go to s_start with r_delay_cnt=p_delay_cnt/2 (floor).
  - s_start: decrement r_delay_cnt; at ==1, sample s (mid start bit).
    - s==1 (glitch): return to s_idle with no pulse.
    - s==0: go to s_data with r_delay_cnt=p_delay_cnt and r_bit_cnt=p_bit_cnt.
  - s_data: at r_delay_cnt==1, shift s into the MSB of the shift register (right shift, so the first bit ends in the LSB), then reload r_delay_cnt=p_delay_cnt. When r_bit_cnt==1, go to s_stop; otherwise decrement r_bit_cnt.
  - s_stop: at r_delay_cnt==1, sample the stop bit.
    - s==1, i_fifo_full=0: next cycle o_fifo_wr_en=1 for exactly 1 cycle, with o_fifo_wr_data=shift register; go to s_idle.
    - s==1, i_fifo_full=1: next cycle o_overrun=1 for 1 cycle, no write; go to s_idle.
    - s==0: next cycle o_frame_err=1 for 1 cycle, no write; go to s_wait.
  - s_wait: stay until s==1, then go to s_idle. This prevents a break condition from being taken as back-to-back start bits.
- Outputs are registered. o_fifo_wr_data holds its last value between strobes. i_fifo_full is sampled only in the stop-sample cycle.
- Sampling points fall at p_delay_cnt/2 + k*p_delay_cnt clocks after s falls, for k=0..p_bit_cnt+1.
- A new start bit is accepted from s_idle on the cycle after the stop sample, so frames with a stop bit only 1/2 bit long are tolerated.
- Tolerance: clock mismatch up to about ±4% between tx and rx for 10-bit frames is required to decode correctly.

Test Plan:
- Loopback with uart_tx, p_delay_cnt=16, p_bit_cnt=8. Bytes 0xA5, 0x00, 0xFF, 0x3C back-to-back -> 4 wr_en pulses carrying the same values in order; no frame_err or overrun.
- Glitch: i_sig low for 4 clocks, then high -> state returns to s_idle; no outputs pulse.
- Framing error: drive 0x55 with the stop bit held low for 3 bit times, then high -> one o_frame_err pulse and no wr_en. The receiver stays in s_wait until the line is high, then receives 0x12 correctly.
- Overrun: i_fifo_full=1 during the frame 0x81 -> one o_overrun pulse, no wr_en. Deassert full and send 0x7E -> wr_en with 0x7E.
- Reset mid-frame: assert i_rst asynchronously during data bit 3 -> outputs 0 immediately, no pulses. After release, frame 0xC3 -> wr_en with 0xC3.
- Timing skew: tx p_delay_cnt=17 against rx p_delay_cnt=16, byte 0x96 -> received 0x96.
